// File: rtl/line_mem_pkg.sv
// Shared types and width derivations for the line-granular backing memory.
package line_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WB_WAIT
    } state_e;

    function automatic int offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_w(input int mem_bytes, input int line_bytes);
        return $clog2(mem_bytes) - $clog2(line_bytes);
    endfunction

    // Counter holds LAT-1 down to 0 for the longer of the two latencies.
    function automatic int cnt_w(input int rd_lat, input int wb_lat);
        int m;
        m = (rd_lat > wb_lat) ? rd_lat : wb_lat;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// Byte-organised line storage: one synchronous line write port, one asynchronous line read port.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int  LINE_BYTES = 16,
    parameter int  MEM_BYTES  = 4096,
    localparam int OFFSET_W   = offset_w(LINE_BYTES),
    localparam int INDEX_W    = index_w(MEM_BYTES, LINE_BYTES),
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] widx_i,
    input  logic [LINE_W-1:0]  wdata_i,
    input  logic [INDEX_W-1:0] ridx_i,
    output logic [LINE_W-1:0]  rdata_o
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                mem[{widx_i, OFFSET_W'(b)}] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            rdata_o[8*b +: 8] = mem[{ridx_i, OFFSET_W'(b)}];
        end
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory behind the Dcache: arbitrates refill reads and writebacks,
// serves one transaction at a time with programmable latency and reports out-of-range accesses.
module line_mem_ctrl
    import line_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int MEM_BYTES  = 4096,
    parameter int RD_LAT     = 3,
    parameter int WB_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Dcache_rd_req_i,
    input  logic [ADDR_W-1:0]       Dcache_rd_addr_i,
    input  logic                    Dcache_wb_req_i,
    input  logic [ADDR_W-1:0]       Dcache_wb_addr_i,
    input  logic [8*LINE_BYTES-1:0] Dcache_data_ram_i,
    output logic                    ram_rd_accept_o,
    output logic                    ram_wb_accept_o,
    output logic [8*LINE_BYTES-1:0] ram_data_o,
    output logic                    ram_rd_valid_o,
    output logic                    ram_wb_done_o,
    output logic                    ram_err_o
);

    localparam int OFFSET_W = offset_w(LINE_BYTES);
    localparam int INDEX_W  = index_w(MEM_BYTES, LINE_BYTES);
    localparam int MEM_AW   = $clog2(MEM_BYTES);
    localparam int LINE_W   = 8 * LINE_BYTES;
    localparam int CNT_W    = cnt_w(RD_LAT, WB_LAT);

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> MEM_AW) != '0;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  data_q, data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wb_done_q, wb_done_d;
    logic               err_q, err_d;

    logic               rd_accept, wb_accept;
    logic               fire_rd, fire_wb;
    logic [ADDR_W-1:0]  tgt_addr;
    logic [LINE_W-1:0]  wline;
    logic [LINE_W-1:0]  rline;
    logic [INDEX_W-1:0] line_idx;
    logic               oor;
    logic               mem_we;

    // A one-cycle latency completes on the accept edge, so the target comes straight from the inputs.
    always_comb begin
        tgt_addr = addr_q;
        wline    = wdata_q;
        if (state_q == IDLE) begin
            tgt_addr = Dcache_wb_req_i ? Dcache_wb_addr_i : Dcache_rd_addr_i;
            wline    = Dcache_data_ram_i;
        end
    end

    assign oor      = out_of_range(tgt_addr);
    assign line_idx = tgt_addr[MEM_AW-1:OFFSET_W];

    line_mem_array #(
        .LINE_BYTES (LINE_BYTES),
        .MEM_BYTES  (MEM_BYTES)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .widx_i  (line_idx),
        .wdata_i (wline),
        .ridx_i  (line_idx),
        .rdata_o (rline)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        wb_done_d  = 1'b0;
        err_d      = 1'b0;
        rd_accept  = 1'b0;
        wb_accept  = 1'b0;
        fire_rd    = 1'b0;
        fire_wb    = 1'b0;

        // Responses are registered on the edge that ends the cycle with cnt==1,
        // so they are visible during the final (cnt==0) wait cycle.
        case (state_q)
            IDLE: begin
                if (!rst && Dcache_wb_req_i) begin
                    wb_accept = 1'b1;
                    addr_d    = Dcache_wb_addr_i;
                    wdata_d   = Dcache_data_ram_i;
                    cnt_d     = CNT_W'(WB_LAT - 1);
                    state_d   = WB_WAIT;
                    fire_wb   = (WB_LAT == 1);
                end else if (!rst && Dcache_rd_req_i) begin
                    rd_accept = 1'b1;
                    addr_d    = Dcache_rd_addr_i;
                    cnt_d     = CNT_W'(RD_LAT - 1);
                    state_d   = RD_WAIT;
                    fire_rd   = (RD_LAT == 1);
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    fire_rd = (cnt_q == CNT_W'(1));
                end
            end
            WB_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    fire_wb = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire_rd) begin
            rd_valid_d = 1'b1;
            err_d      = oor;
            data_d     = oor ? '0 : rline;
        end
        if (fire_wb) begin
            wb_done_d = 1'b1;
            err_d     = oor;
        end
    end

    // Commit shares the completion edge; a reset on that edge drops the write.
    assign mem_we = fire_wb && !oor && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            wb_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            wb_done_q  <= wb_done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign ram_rd_accept_o = rd_accept;
    assign ram_wb_accept_o = wb_accept;
    assign ram_data_o      = data_q;
    assign ram_rd_valid_o  = rd_valid_q;
    assign ram_wb_done_o   = wb_done_q;
    assign ram_err_o       = err_q;

endmodule
